// File: rtl/instr_fetch.sv
// Instruction fetch: holds the fetch PC, issues one imem read at a time and buffers the returned word.
// Define FETCH_MISALIGN_EN to halt on a misaligned redirect target.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   output logic        misalign
);

`ifdef FETCH_MISALIGN_EN
   typedef enum logic [1:0] {REQ, WAIT, HALT} state_e;
`else
   typedef enum logic {REQ, WAIT} state_e;
`endif

   state_e      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        discard_q, discard_d;
   logic        buf_v_q, buf_v_d;
   logic [31:0] buf_data_q, buf_data_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic        req_v;
   logic        accept;
   logic        halted;

`ifdef FETCH_MISALIGN_EN
   logic        mis_q, mis_d;
   logic        bad_tgt;

   assign halted   = (state_q == HALT);
   assign bad_tgt  = (redirect_pc[1:0] != 2'b00);
   assign misalign = mis_q;
`else
   logic        unused_lsb;

   assign halted     = 1'b0;
   assign unused_lsb = ^redirect_pc[1:0];
   assign misalign   = 1'b0;
`endif

   assign req_v          = (state_q == REQ) & (~buf_v_q | inst_ready);
   assign accept         = req_v & imem_req_ready;
   assign imem_req_valid = req_v & ~rst;
   assign imem_req_addr  = fetch_pc_q;
   assign inst_valid     = buf_v_q;
   assign inst_data      = buf_data_q;
   assign inst_pc        = buf_pc_q;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      discard_d  = discard_q;
      buf_v_d    = buf_v_q;
      buf_data_d = buf_data_q;
      buf_pc_d   = buf_pc_q;
`ifdef FETCH_MISALIGN_EN
      mis_d      = mis_q;
`endif
      if (redirect & ~halted) begin
         buf_v_d = 1'b0;
         // a squashed request still owes us a response; drain it
         if (accept) begin
            state_d   = WAIT;
            discard_d = 1'b1;
         end else if ((state_q == WAIT) & ~imem_rsp_valid) begin
            discard_d = 1'b1;
         end else begin
            state_d   = REQ;
            discard_d = 1'b0;
         end
`ifdef FETCH_MISALIGN_EN
         if (bad_tgt) begin
            mis_d   = 1'b1;
            state_d = HALT;
         end else begin
            fetch_pc_d = redirect_pc;
         end
`else
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
`endif
      end else begin
         if (buf_v_q & inst_ready) buf_v_d = 1'b0;
         unique case (state_q)
            REQ: begin
               if (accept) begin
                  req_pc_d   = fetch_pc_q;
                  fetch_pc_d = fetch_pc_q + 32'd4;
                  state_d    = WAIT;
               end
            end
            WAIT: begin
               if (imem_rsp_valid) begin
                  state_d   = REQ;
                  discard_d = 1'b0;
                  if (~discard_q) begin
                     buf_v_d    = 1'b1;
                     buf_data_d = imem_rsp_data;
                     buf_pc_d   = req_pc_q;
                  end
               end
            end
`ifdef FETCH_MISALIGN_EN
            HALT: begin
               if (imem_rsp_valid) discard_d = 1'b0;
            end
`endif
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= REQ;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= 32'd0;
         discard_q  <= 1'b0;
         buf_v_q    <= 1'b0;
         buf_data_q <= 32'd0;
         buf_pc_q   <= 32'd0;
`ifdef FETCH_MISALIGN_EN
         mis_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         discard_q  <= discard_d;
         buf_v_q    <= buf_v_d;
         buf_data_q <= buf_data_d;
         buf_pc_q   <= buf_pc_d;
`ifdef FETCH_MISALIGN_EN
         mis_q      <= mis_d;
`endif
      end
   end

endmodule
